pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and stage-control unit for the 5-stage MIPS pipeline. It replaces the fixed-depth stall logic with three mechanisms: counter-driven branch flushing of configurable depth, multi-cycle EXE operation stalls (mul/div), and saturating performance counters for stall and flush cycles. It sits beside the decoder in ID and drives the per-stage enable/reset signals and the EXE operand-forwarding selects.

## Interface
- ADDR_W, 5: register address width
- BR_FLUSH, 3: ID bubbles inserted per accepted jump/branch; 0 = delay-slot mode, no flush
- MUL_LAT, 4: cycles a multi-cycle op occupies EXE (≥1); 1 = no stall
- CNT_W, 32: performance counter width
- DEBUG, 1: 1 = debug hold/step logic present; 0 = debug_en ignored
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- debug_en  in  1  freeze pipeline except on single step
- debug_step  in  1  step request, rising-edge detected
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  ADDR_W  source registers in ID
- id_rs_used, id_rt_used  in  1  source actually read
- id_is_branch  in  1  ID instruction is jump/branch
- id_is_multi  in  1  ID instruction is multi-cycle EXE op
- exe_wen, mem_wen  in  1  write-back enable of EXE / MEM instruction
- exe_waddr, mem_waddr  in  ADDR_W  destination of EXE / MEM instruction
- exe_is_load  in  1  EXE instruction writes back memory data
- fwd_a, fwd_b  out  2  00 none, 01 EXE ALU result, 10 MEM-stage write-back data, 11 unused
- if_en, id_en, exe_en, mem_en, wb_en  out  1  stage enables
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1  stage resets (bubble insert)
- busy  out  1  multi-cycle op in progress
- stall_cycles, flush_cycles  out  CNT_W  saturating performance counters

## Operation
- Hazard check per source X ∈ {rs, rt}, only when X_used && addr≠0 && id_valid:
  - exe_wen && exe_waddr==addr: if exe_is_load, assert load_stall and fwd=00; otherwise fwd=01.
  - else if mem_wen && mem_waddr==addr: fwd=10.
  - else fwd=00. The EXE match always wins over the MEM match.
- Stage control defaults: all *_en=1, all *_rst=0. Priority, highest first:
  1. rst: all *_rst=1.
  2. Debug hold (DEBUG && debug_en && no step edge): all *_en=0.
  3. busy: if_en=id_en=exe_en=0, mem_rst=1.
  4. load_stall: if_en=id_en=0, exe_rst=1.
  5. Branch flush: id_rst=1.
- Step edge is debug_step && !step_prev. step_prev is registered every cycle and resets to 0.
- Branch accepted: id_valid && id_is_branch && no higher-priority condition.
  - On acceptance with BR_FLUSH≥1: id_rst=1 that cycle, and br_cnt loads BR_FLUSH−1.
  - While br_cnt≠0: id_rst=1 and br_cnt decrements.
  - Total bubbles = BR_FLUSH.
- Multi-cycle op accepted: id_valid && id_is_multi && ID advancing (no rst, hold, busy or load_stall).
  - mul_cnt loads MUL_LAT−1.
  - busy = (mul_cnt≠0).
  - mul_cnt decrements each cycle it is nonzero.
- Debug hold freezes br_cnt, mul_cnt and both perf counters.
- Perf counters (both saturate at all-ones):
  - stall_cycles +1 each non-hold cycle with busy or load_stall.
  - flush_cycles +1 each non-hold cycle where id_rst is asserted by branch flush.
- Branch flags are qualified by id_valid, so a flush bubble can never re-trigger a flush.
- A branch held by load_stall is accepted on the first non-stalled cycle.

## Timing
- fwd_*, all *_en and *_rst are combinational from inputs plus registered state, with zero latency.
- Reset values: br_cnt=0, mul_cnt=0, busy=0, step_prev=0, stall_cycles=0, flush_cycles=0.
- While rst=1: fwd=00, all *_en=1, all *_rst=1.
- rst mid-flush or mid-multi clears the counters on the next edge; the pipeline resumes with no residual stall.
- A multi-op in EXE holds EXE for MUL_LAT cycles total. Its result forwards as fwd=01 in the cycle after busy drops.
- Load-use costs exactly 1 stall cycle. The following cycle forwards via 10.

## Test plan
- Load-use: lw writes r3 in EXE (exe_is_load=1), ID add reads rs=r3 -> 1 cycle with if_en=id_en=0, exe_rst=1, fwd_a=00. Next cycle, with the load now in MEM (mem_wen=1, mem_waddr=r3), fwd_a=10; stall_cycles=1.
- Priority: exe_waddr=mem_waddr=r5, both ALU, ID rt=r5 -> fwd_b=01. Same case with rt=r0 -> fwd_b=00.
- Branch, BR_FLUSH=3: beq accepted at cycle t -> id_rst=1 at t, t+1, t+2 and 0 at t+3; flush_cycles=3. With BR_FLUSH=0 -> id_rst never asserted.
- Multi-op, MUL_LAT=4: mul leaves ID at t -> busy=1 and mem_rst=1 at t+1..t+3, busy=0 at t+4; stall_cycles=3.
- Debug: debug_en=1 with step held low for 5 cycles -> all *_en=0 and counters frozen. A single 0->1 step gives exactly one cycle with all *_en=1.
- Reset mid-multi: rst pulsed at t+2 of a MUL_LAT=4 op -> busy=0 at t+3, all counters 0, all *_rst=1 during the rst cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, EXE operand forwarding and per-stage enable/reset control for the
// 5-stage pipeline: load-use stalls, counted branch flushes, multi-cycle EXE ops, debug hold.
module pipe_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int BR_FLUSH = 3,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 32,
  parameter int DEBUG    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_branch,
  input  logic              id_is_multi,
  input  logic              exe_wen,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] exe_waddr,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic              exe_is_load,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
);
  localparam int BW       = (BR_FLUSH > 1) ? $clog2(BR_FLUSH) : 1;
  localparam int MW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int BR_LOAD  = (BR_FLUSH > 0) ? BR_FLUSH - 1 : 0;
  localparam int MUL_LOAD = (MUL_LAT > 0) ? MUL_LAT - 1 : 0;

  logic [BW-1:0] br_cnt;
  logic [MW-1:0] mul_cnt;
  logic          step_prev;
  logic          step_edge, hold, load_stall, br_accept, mul_accept, flush;

  // source 0 = rs, source 1 = rt
  logic [1:0][ADDR_W-1:0] src_addr;
  logic [1:0]             src_en, src_stall;
  logic [1:0][1:0]        src_fwd;

  assign src_addr = {id_rt_addr, id_rs_addr};
  assign src_en   = {id_valid & id_rt_used & ~rst, id_valid & id_rs_used & ~rst};

  for (genvar g = 0; g < 2; g++) begin : g_src
    logic [1:0] fwd;
    logic       stl;
    always_comb begin
      fwd = 2'b00;
      stl = 1'b0;
      if (src_en[g] && src_addr[g] != '0) begin
        if (exe_wen && exe_waddr == src_addr[g]) begin
          if (exe_is_load) stl = 1'b1;
          else             fwd = 2'b01;
        end else if (mem_wen && mem_waddr == src_addr[g]) begin
          fwd = 2'b10;
        end
      end
    end
    assign src_fwd[g]   = fwd;
    assign src_stall[g] = stl;
  end

  assign fwd_a      = src_fwd[0];
  assign fwd_b      = src_fwd[1];
  assign load_stall = |src_stall;

  assign step_edge  = debug_step & ~step_prev;
  assign hold       = (DEBUG != 0) & debug_en & ~step_edge & ~rst;
  assign busy       = (mul_cnt != '0);
  assign br_accept  = id_valid & id_is_branch & ~rst & ~hold & ~busy & ~load_stall;
  assign mul_accept = id_valid & id_is_multi & ~rst & ~hold & ~busy & ~load_stall;
  // bubbles continue from br_cnt even if a later stall overlaps the flush window
  assign flush      = ~rst & ~hold & (((BR_FLUSH > 0) & br_accept) | (br_cnt != '0));

  always_comb begin
    {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b11111;
    {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b00000;
    if (rst) begin
      {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
    end else if (hold) begin
      {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00000;
    end else begin
      if (busy) begin
        if_en   = 1'b0;
        id_en   = 1'b0;
        exe_en  = 1'b0;
        mem_rst = 1'b1;
      end else if (load_stall) begin
        if_en   = 1'b0;
        id_en   = 1'b0;
        exe_rst = 1'b1;
      end
      if (flush) id_rst = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt       <= '0;
      mul_cnt      <= '0;
      step_prev    <= 1'b0;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      step_prev <= debug_step;
      if (!hold) begin
        if (br_accept && BR_FLUSH > 0) br_cnt <= BW'(BR_LOAD);
        else if (br_cnt != '0)         br_cnt <= br_cnt - 1'b1;
        if (mul_accept) mul_cnt <= MW'(MUL_LOAD);
        else if (busy)  mul_cnt <= mul_cnt - 1'b1;
        if ((busy || load_stall) && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
        if (flush && !(&flush_cycles))                flush_cycles <= flush_cycles + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: default-parameter DUT plus a second instance with
// BR_FLUSH=0, MUL_LAT=1, CNT_W=2, DEBUG=0 driven by the same stimulus.
module tb_pipe_hazard_ctrl;
  logic       clk, rst, debug_en, debug_step, id_valid;
  logic [4:0] id_rs_addr, id_rt_addr, exe_waddr, mem_waddr;
  logic       id_rs_used, id_rt_used, id_is_branch, id_is_multi;
  logic       exe_wen, mem_wen, exe_is_load;

  logic [1:0]  fwd_a1, fwd_b1, fwd_a2, fwd_b2;
  logic        if_en1, id_en1, exe_en1, mem_en1, wb_en1, if_rst1, id_rst1, exe_rst1, mem_rst1, wb_rst1, busy1;
  logic        if_en2, id_en2, exe_en2, mem_en2, wb_en2, if_rst2, id_rst2, exe_rst2, mem_rst2, wb_rst2, busy2;
  logic [31:0] stall1, flush1;
  logic [1:0]  stall2, flush2;

  pipe_hazard_ctrl #(.ADDR_W(5), .BR_FLUSH(3), .MUL_LAT(4), .CNT_W(32), .DEBUG(1)) u_dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_branch(id_is_branch), .id_is_multi(id_is_multi), .exe_wen(exe_wen), .mem_wen(mem_wen),
    .exe_waddr(exe_waddr), .mem_waddr(mem_waddr), .exe_is_load(exe_is_load),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .if_en(if_en1), .id_en(id_en1), .exe_en(exe_en1), .mem_en(mem_en1),
    .wb_en(wb_en1), .if_rst(if_rst1), .id_rst(id_rst1), .exe_rst(exe_rst1), .mem_rst(mem_rst1),
    .wb_rst(wb_rst1), .busy(busy1), .stall_cycles(stall1), .flush_cycles(flush1));

  pipe_hazard_ctrl #(.ADDR_W(5), .BR_FLUSH(0), .MUL_LAT(1), .CNT_W(2), .DEBUG(0)) u_dut2 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_branch(id_is_branch), .id_is_multi(id_is_multi), .exe_wen(exe_wen), .mem_wen(mem_wen),
    .exe_waddr(exe_waddr), .mem_waddr(mem_waddr), .exe_is_load(exe_is_load),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .if_en(if_en2), .id_en(id_en2), .exe_en(exe_en2), .mem_en(mem_en2),
    .wb_en(wb_en2), .if_rst(if_rst2), .id_rst(id_rst2), .exe_rst(exe_rst2), .mem_rst(mem_rst2),
    .wb_rst(wb_rst2), .busy(busy2), .stall_cycles(stall2), .flush_cycles(flush2));

  logic [14:0] o1, o2;
  assign o1 = {fwd_a1, fwd_b1, if_en1, id_en1, exe_en1, mem_en1, wb_en1,
               if_rst1, id_rst1, exe_rst1, mem_rst1, wb_rst1, busy1};
  assign o2 = {fwd_a2, fwd_b2, if_en2, id_en2, exe_en2, mem_en2, wb_en2,
               if_rst2, id_rst2, exe_rst2, mem_rst2, wb_rst2, busy2};

  typedef struct { string name; logic [14:0] e1; logic [14:0] e2; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   total, bad;

  // priority table: rt address, id_valid, exe_waddr, expected fwd_b
  localparam logic [4:0] PRI_RT [4] = '{5'd5, 5'd0, 5'd5, 5'd5};
  localparam logic       PRI_V  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [4:0] PRI_EA [4] = '{5'd5, 5'd5, 5'd5, 5'd6};
  localparam logic [1:0] PRI_FB [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
  // debug sequence: debug_en, step, multi per cycle; expected code bit0=hold, bit1=busy
  localparam logic [15:0] D_EN   = 16'h71FE;
  localparam logic [15:0] D_STEP = 16'h60C0;
  localparam logic [15:0] D_MUL  = 16'h0001;
  localparam logic [1:0]  D_EXP [16] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3,
                                         2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};

  function automatic logic [14:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [4:0] en, input logic [4:0] rs, input logic b);
    return {fa, fb, en, rs, b};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    debug_en = 0; debug_step = 0; id_valid = 0; id_rs_addr = 0; id_rt_addr = 0;
    id_rs_used = 0; id_rt_used = 0; id_is_branch = 0; id_is_multi = 0;
    exe_wen = 0; mem_wen = 0; exe_waddr = 0; mem_waddr = 0; exe_is_load = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; id_valid = 1; id_rs_used = 1; id_rs_addr = 3; exe_wen = 1; exe_waddr = 3;
    id_is_branch = 1; id_is_multi = 1;
    sb.push_back('{name:"reset_active", e1:mk(0, 0, 5'b11111, 5'b11111, 0), e2:mk(0, 0, 5'b11111, 5'b11111, 0)});
    @(negedge clk); e = sb.pop_front(); total++;
    if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s got=%h/%h want=%h/%h", e.name, o1, o2, e.e1, e.e2); end
    @(posedge clk); #1;
    rst = 0; idle();
    sb.push_back('{name:"reset_idle", e1:mk(0, 0, 5'b11111, 0, 0), e2:mk(0, 0, 5'b11111, 0, 0)});
    @(negedge clk); e = sb.pop_front(); total++;
    if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s got=%h/%h want=%h/%h", e.name, o1, o2, e.e1, e.e2); end
    total++;
    if (stall1 !== 0 || flush1 !== 0 || stall2 !== 0 || flush2 !== 0) begin
      bad++; $display("FAIL reset_counters got=%0d,%0d,%0d,%0d want=0,0,0,0", stall1, flush1, stall2, flush2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      id_valid = 1; id_rs_used = 1; id_rs_addr = 3; id_rt_used = 1; id_rt_addr = 7; mem_wen = 1;
      if (i == 0) begin
        exe_wen = 1; exe_waddr = 3; exe_is_load = 1; mem_waddr = 7;
        sb.push_back('{name:"load_use_stall", e1:mk(0, 2'b10, 5'b00111, 5'b00100, 0), e2:mk(0, 2'b10, 5'b00111, 5'b00100, 0)});
      end else begin
        exe_wen = 0; exe_is_load = 0; mem_waddr = 3;
        sb.push_back('{name:"load_use_fwd", e1:mk(2'b10, 0, 5'b11111, 0, 0), e2:mk(2'b10, 0, 5'b11111, 0, 0)});
      end
      @(negedge clk); e = sb.pop_front(); total++;
      if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s got=%h/%h want=%h/%h", e.name, o1, o2, e.e1, e.e2); end
      @(posedge clk); #1;
    end
    total++;
    if (stall1 !== 1 || stall2 !== 1) begin bad++; $display("FAIL load_use_stall_cnt got=%0d/%0d want=1/1", stall1, stall2); end
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      id_valid = PRI_V[i]; id_rt_used = 1; id_rt_addr = PRI_RT[i];
      id_rs_used = 0; id_rs_addr = 5;
      exe_wen = 1; exe_waddr = PRI_EA[i]; mem_wen = 1; mem_waddr = 5;
      sb.push_back('{name:"priority", e1:mk(0, PRI_FB[i], 5'b11111, 0, 0), e2:mk(0, PRI_FB[i], 5'b11111, 0, 0)});
      @(negedge clk); e = sb.pop_front(); total++;
      if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s[%0d] got=%h/%h want=%h/%h", e.name, i, o1, o2, e.e1, e.e2); end
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 0) begin id_valid = 1; id_is_branch = 1; end
      sb.push_back('{name:"branch_flush", e1:mk(0, 0, 5'b11111, (i < 3) ? 5'b01000 : 5'b00000, 0), e2:mk(0, 0, 5'b11111, 0, 0)});
      @(negedge clk); e = sb.pop_front(); total++;
      if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s[%0d] got=%h/%h want=%h/%h", e.name, i, o1, o2, e.e1, e.e2); end
      @(posedge clk); #1;
    end
    total++;
    if (flush1 !== 3 || flush2 !== 0) begin bad++; $display("FAIL branch_flush_cnt got=%0d/%0d want=3/0", flush1, flush2); end
    idle();
  endtask

  task automatic test_branch_after_load();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i == 0) begin
        id_valid = 1; id_is_branch = 1; id_rs_used = 1; id_rs_addr = 3;
        exe_wen = 1; exe_waddr = 3; exe_is_load = 1;
        sb.push_back('{name:"br_load_stall", e1:mk(0, 0, 5'b00111, 5'b00100, 0), e2:mk(0, 0, 5'b00111, 5'b00100, 0)});
      end else if (i == 1) begin
        id_valid = 1; id_is_branch = 1; id_rs_used = 1; id_rs_addr = 3; mem_wen = 1; mem_waddr = 3;
        sb.push_back('{name:"br_accept_late", e1:mk(2'b10, 0, 5'b11111, 5'b01000, 0), e2:mk(2'b10, 0, 5'b11111, 0, 0)});
      end else begin
        sb.push_back('{name:"br_late_flush", e1:mk(0, 0, 5'b11111, (i < 4) ? 5'b01000 : 5'b00000, 0), e2:mk(0, 0, 5'b11111, 0, 0)});
      end
      @(negedge clk); e = sb.pop_front(); total++;
      if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s[%0d] got=%h/%h want=%h/%h", e.name, i, o1, o2, e.e1, e.e2); end
      @(posedge clk); #1;
    end
    total++;
    if (flush1 !== 3 || stall1 !== 1) begin bad++; $display("FAIL br_load_cnts got=%0d/%0d want=3/1", flush1, stall1); end
    idle();
  endtask

  task automatic test_multi();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i == 0) begin
        id_valid = 1; id_is_multi = 1;
        sb.push_back('{name:"multi_accept", e1:mk(0, 0, 5'b11111, 0, 0), e2:mk(0, 0, 5'b11111, 0, 0)});
      end else if (i < 4) begin
        sb.push_back('{name:"multi_busy", e1:mk(0, 0, 5'b00011, 5'b00010, 1), e2:mk(0, 0, 5'b11111, 0, 0)});
      end else begin
        id_valid = 1; id_rs_used = 1; id_rs_addr = 4; exe_wen = 1; exe_waddr = 4;
        sb.push_back('{name:"multi_done_fwd", e1:mk(2'b01, 0, 5'b11111, 0, 0), e2:mk(2'b01, 0, 5'b11111, 0, 0)});
      end
      @(negedge clk); e = sb.pop_front(); total++;
      if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s[%0d] got=%h/%h want=%h/%h", e.name, i, o1, o2, e.e1, e.e2); end
      @(posedge clk); #1;
    end
    total++;
    if (stall1 !== 3 || stall2 !== 0) begin bad++; $display("FAIL multi_stall_cnt got=%0d/%0d want=3/0", stall1, stall2); end
    idle();
  endtask

  task automatic test_debug();
    logic h, b;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle();
      debug_en = D_EN[i]; debug_step = D_STEP[i];
      if (D_MUL[i]) begin id_valid = 1; id_is_multi = 1; end
      h = D_EXP[i][0]; b = D_EXP[i][1];
      sb.push_back('{name:"debug", e1:mk(0, 0, h ? 5'b00000 : (b ? 5'b00011 : 5'b11111), (!h && b) ? 5'b00010 : 5'b00000, b),
                     e2:mk(0, 0, 5'b11111, 0, 0)});
      @(negedge clk); e = sb.pop_front(); total++;
      if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s[%0d] got=%h/%h want=%h/%h", e.name, i, o1, o2, e.e1, e.e2); end
      if (i == 6) begin
        total++;
        if (stall1 !== 0) begin bad++; $display("FAIL debug_frozen_cnt got=%0d want=0", stall1); end
      end
      @(posedge clk); #1;
    end
    total++;
    if (stall1 !== 3 || stall2 !== 0) begin bad++; $display("FAIL debug_stall_cnt got=%0d/%0d want=3/0", stall1, stall2); end
    idle();
  endtask

  task automatic test_reset_mid_multi();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      rst = (i == 2);
      if (i == 0) begin
        id_valid = 1; id_is_multi = 1;
        sb.push_back('{name:"rmm_accept", e1:mk(0, 0, 5'b11111, 0, 0), e2:mk(0, 0, 5'b11111, 0, 0)});
      end else if (i == 1) begin
        sb.push_back('{name:"rmm_busy", e1:mk(0, 0, 5'b00011, 5'b00010, 1), e2:mk(0, 0, 5'b11111, 0, 0)});
      end else if (i == 2) begin
        sb.push_back('{name:"rmm_rst", e1:mk(0, 0, 5'b11111, 5'b11111, 1), e2:mk(0, 0, 5'b11111, 5'b11111, 0)});
      end else begin
        sb.push_back('{name:"rmm_after", e1:mk(0, 0, 5'b11111, 0, 0), e2:mk(0, 0, 5'b11111, 0, 0)});
      end
      @(negedge clk); e = sb.pop_front(); total++;
      if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s got=%h/%h want=%h/%h", e.name, o1, o2, e.e1, e.e2); end
      @(posedge clk); #1;
    end
    rst = 0;
    total++;
    if (stall1 !== 0 || flush1 !== 0) begin bad++; $display("FAIL rmm_counters got=%0d/%0d want=0/0", stall1, flush1); end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      id_valid = 1; id_rt_used = 1; id_rt_addr = 9; exe_wen = 1; exe_waddr = 9; exe_is_load = 1;
      sb.push_back('{name:"sat_stall", e1:mk(0, 0, 5'b00111, 5'b00100, 0), e2:mk(0, 0, 5'b00111, 5'b00100, 0)});
      @(negedge clk); e = sb.pop_front(); total++;
      if (o1 !== e.e1 || o2 !== e.e2) begin bad++; $display("FAIL %s[%0d] got=%h/%h want=%h/%h", e.name, i, o1, o2, e.e1, e.e2); end
      @(posedge clk); #1;
    end
    total++;
    if (stall1 !== 5 || stall2 !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d/%0d want=5/3", stall1, stall2); end
    idle();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1; idle();
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_priority();
    test_branch();
    test_branch_after_load();
    test_multi();
    test_debug();
    test_reset_mid_multi();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
